bp_sched: RTL and testbench
===========================

Name: bp_sched

Overview:
- Sequencer for the polar-code BP decoder processing-element (PE) array.
- The PEs are the pipelined min-sum f/g units: registered inputs and registered output, all gated by a single enable.
- The block walks the factor graph stage by stage, in an L-sweep followed by an R-sweep, for max_iter iterations.
- Per butterfly group it issues BRAM read addresses, drives the shared PE enable, and issues the matching write-back after the fixed pipeline latency.
- It sits between the top-level decode control (start/done) and the message BRAMs plus the PE array.

Parameters:
- N_LOG2, 6, log2 of code length N (stages S_N = N_LOG2).
- P_LOG2, 2, log2 of parallel PE count P. Requires P_LOG2 < N_LOG2.
- LAT, 3, read-to-write latency in enabled cycles (1 BRAM + 2 PE).
- ITER_W, 6, width of the iteration count.
- Derived: G = 2^(N_LOG2-1-P_LOG2) butterfly groups per stage; GA_W = max(1, N_LOG2-1-P_LOG2); ST_W = clog2(N_LOG2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  begin decode; sampled only in IDLE.
- abort  in  1  cancel decode; flush to IDLE, no done.
- max_iter  in  ITER_W  iteration count; sampled with start.
- stall  in  1  BRAM port busy; freezes the schedule.
- busy  out  1  decode in progress.
- done  out  1  one-cycle pulse after the final write-back.
- iter_cnt  out  ITER_W  current iteration, 0-based.
- pe_en  out  1  enable to all PEs.
- rd_en  out  1  read issue.
- rd_grp  out  GA_W  group index.
- rd_stage  out  ST_W  stage index.
- rd_dir  out  1  0 = L-sweep, 1 = R-sweep.
- wr_en  out  1  write-back strobe.
- wr_grp  out  GA_W  group index.
- wr_stage  out  ST_W  stage index.
- wr_dir  out  1  sweep direction.

Behaviour:
- Reset (asynchronous): state IDLE; all outputs 0; delay line cleared.

FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - start=1 and max_iter>0: latch max_iter, go to RUN. First rd_en occurs in the next cycle (cycle 1 if start is sampled at cycle 0).
  - start=1 and max_iter=0: go to DONE directly; no reads issued.
- RUN:
  - Each stage issues G reads, rd_grp = 0..G-1, one per non-stalled cycle.
  - It then inserts LAT bubble cycles (non-stalled) so the stage's writes complete before the next stage reads.
  - Stage period is therefore G+LAT enabled cycles.
  - Stage order per iteration: L-sweep with rd_stage N_LOG2-1 down to 0, rd_dir=0; then R-sweep with rd_stage 0 up to N_LOG2-1, rd_dir=1.
  - iter_cnt increments after the R-sweep's last stage.
  - After iteration max_iter-1 completes, go to FLUSH.
- FLUSH: wait until the last write-back has been issued, then go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.

Delay line:
- LAT-deep shift register of {valid, grp, stage, dir}.
- Advances only when pe_en=1.
- wr_en = tail valid & pe_en; wr_grp, wr_stage and wr_dir come from the tail entry.

Stall and enable:
- pe_en = ~stall whenever busy, else 0.
- stall=1 freezes group/stage/iteration counters, bubble counter and delay line; rd_en=0 and wr_en=0 during stall.

Timing:
- busy rises the cycle after start is accepted and falls in the DONE cycle.
- With no stall, total reads = 2*N_LOG2*G*max_iter.
- The last write occurs at cycle 2*N_LOG2*max_iter*(G+LAT); done follows in the next cycle.

Boundary and precedence rules:
- start while busy is ignored.
- abort in any non-IDLE state: next cycle IDLE, delay line cleared, wr_en suppressed, no done.
- abort has priority over stall; rst has priority over everything.
- A stall arriving in the same cycle as a stage boundary holds the boundary; no group is skipped or repeated.
- max_iter = all-ones is legal; iter_cnt must not overflow before termination.

Decomposition:
- Shared package bp_pkg holds:
  - constants for stage/group width derivation;
  - DIR_L = 0, DIR_R = 1;
  - FSM state enum;
  - struct for delay-line entry {valid, grp, stage, dir}.
- One natural sub-module: bp_sched_dly, the LAT-deep enabled delay line with synchronous flush and async reset.

Test Plan:
- All tests use N_LOG2=3, P_LOG2=1, LAT=3, so G=2 and the stage period is 5.
- Basic run:
  - Stimulus: start at cycle 0, max_iter=1.
  - Response: 12 reads; stage sequence 2,1,0 (dir 0) then 0,1,2 (dir 1).
  - Write of stage 2 group 0 at cycle 4; last write at cycle 30; done at 31.
- Two iterations, no stall:
  - Stimulus: max_iter=2.
  - Response: 24 reads and 24 writes; wr_* equals rd_* delayed exactly 3 cycles; last write at cycle 60; done at 61; iter_cnt 0 then 1.
- Stall:
  - Stimulus: stall high for cycles 3..6 during stage 2.
  - Response: pe_en=0 and no rd_en/wr_en in cycles 3..6; schedule shifts by 4; done at 35 (max_iter=1); same address sequence.
- Zero iterations:
  - Stimulus: start with max_iter=0.
  - Response: no rd_en/wr_en; done pulse at cycle 1; busy never rises.
- Abort and restart:
  - Stimulus: abort at cycle 8 while in RUN.
  - Response: IDLE at cycle 9; wr_en stays 0 thereafter; no done.
  - A new start at cycle 12 runs a full correct schedule.
- Async reset mid-run:
  - Stimulus: rst pulse between clock edges at cycle 15.
  - Response: all outputs 0 immediately, without waiting for a clock edge; start ignored while rst is high.

Source files
------------

// File: rtl/bp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : bp_pkg                                                         |
// | Purpose   : Shared types and helpers for the polar BP decoder scheduler:   |
// |             width derivation, sweep-direction codes, FSM state encoding    |
// |             and the delay-line entry carried from read to write-back.      |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
package bp_pkg;

  // Storage widths of the delay-line entry fields. Module parameters must
  // keep their group/stage widths at or below these.
  localparam int GRP_MAX_W = 16;
  localparam int ST_MAX_W  = 8;

  localparam logic DIR_L = 1'b0;  // L-sweep: stage N_LOG2-1 down to 0
  localparam logic DIR_R = 1'b1;  // R-sweep: stage 0 up to N_LOG2-1

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic                 valid;
    logic [GRP_MAX_W-1:0] grp;
    logic [ST_MAX_W-1:0]  stage;
    logic                 dir;
  } dly_entry_t;

  // Group index width: log2(G), never below one bit.
  function automatic int grp_width(input int n_log2, input int p_log2);
    return ((n_log2 - 1 - p_log2) > 1) ? (n_log2 - 1 - p_log2) : 1;
  endfunction

  // Width of a counter holding 0..n-1, never below one bit.
  function automatic int cnt_width(input int n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bp_sched_dly.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : bp_sched_dly                                                   |
// | Purpose   : LAT-deep enabled delay line that carries each read's           |
// |             {valid, grp, stage, dir} to its write-back slot.               |
// | Ports     : clk, rst     clock, asynchronous active-high reset             |
// |             flush_i      synchronous clear of every slot                   |
// |             en_i         advance (shared PE enable)                        |
// |             din_i        entry entering slot 0                             |
// |             tail_o       oldest entry (slot LAT-1)                         |
// |             pending_o    some entry other than the tail is still valid     |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module bp_sched_dly
  import bp_pkg::*;
#(
  parameter int LAT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush_i,
  input  logic       en_i,
  input  dly_entry_t din_i,
  output dly_entry_t tail_o,
  output logic       pending_o
);

  dly_entry_t slot_q [LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) slot_q[i] <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < LAT; i++) slot_q[i] <= '0;
    end else if (en_i) begin
      slot_q[0] <= din_i;
      for (int i = 1; i < LAT; i++) slot_q[i] <= slot_q[i-1];
    end
  end

  assign tail_o = slot_q[LAT-1];

  // Once nothing but the tail is valid, the tail write is the last one.
  always_comb begin
    pending_o = 1'b0;
    for (int i = 0; i < LAT - 1; i++) pending_o = pending_o | slot_q[i].valid;
  end

endmodule
`default_nettype wire

// File: rtl/bp_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : bp_sched                                                       |
// | Purpose   : Sequencer for the polar BP decoder PE array. Walks the factor  |
// |             graph as an L-sweep then an R-sweep per iteration, issuing     |
// |             one group read per enabled cycle, LAT bubbles per stage, and   |
// |             the matching write-back LAT enabled cycles after each read.    |
// | Ports     : clk, rst          clock, asynchronous active-high reset        |
// |             start_i/abort_i   begin / cancel a decode                      |
// |             max_iter_i        iteration count, sampled with start_i        |
// |             stall_i           BRAM busy, freezes the whole schedule        |
// |             busy_o/done_o     decode in progress / completion pulse        |
// |             iter_cnt_o        current iteration (0-based)                  |
// |             pe_en_o           shared PE enable                             |
// |             rd_*_o / wr_*_o   read issue and write-back address fields     |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module bp_sched
  import bp_pkg::*;
#(
  parameter  int N_LOG2 = 6,
  parameter  int P_LOG2 = 2,
  parameter  int LAT    = 3,
  parameter  int ITER_W = 6,
  localparam int GA_W   = grp_width(N_LOG2, P_LOG2),
  localparam int ST_W   = cnt_width(N_LOG2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ITER_W-1:0] max_iter_i,
  input  logic              stall_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ITER_W-1:0] iter_cnt_o,
  output logic              pe_en_o,
  output logic              rd_en_o,
  output logic [GA_W-1:0]   rd_grp_o,
  output logic [ST_W-1:0]   rd_stage_o,
  output logic              rd_dir_o,
  output logic              wr_en_o,
  output logic [GA_W-1:0]   wr_grp_o,
  output logic [ST_W-1:0]   wr_stage_o,
  output logic              wr_dir_o
);

  localparam int              G        = 1 << (N_LOG2 - 1 - P_LOG2);
  localparam int              BUB_W    = cnt_width(LAT);
  localparam logic [GA_W-1:0] GRP_LAST = GA_W'(G - 1);
  localparam logic [ST_W-1:0] ST_LAST  = ST_W'(N_LOG2 - 1);
  localparam logic [BUB_W-1:0] BUB_LAST = BUB_W'(LAT - 1);

  state_e              state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [ITER_W-1:0]   max_q, max_d;
  logic [GA_W-1:0]     grp_q, grp_d;
  logic [ST_W-1:0]     stage_q, stage_d;
  logic                dir_q, dir_d;
  logic                rdph_q, rdph_d;   // 1 = issuing reads, 0 = bubbles
  logic [BUB_W-1:0]    bub_q, bub_d;

  logic                w_abort;
  logic                w_last_stage;
  logic                w_pending;
  dly_entry_t          w_din;
  dly_entry_t          w_tail;

  assign w_abort      = abort_i && (state_q != S_IDLE);
  // Final stage of the final iteration: R-sweep top stage at iteration max-1.
  assign w_last_stage = (dir_q == DIR_R) && (stage_q == ST_LAST) &&
                        (iter_q == max_q - ITER_W'(1));

  assign pe_en_o    = busy_q & ~stall_i;
  assign rd_en_o    = (state_q == S_RUN) & rdph_q & ~stall_i & ~abort_i;
  assign rd_grp_o   = grp_q;
  assign rd_stage_o = stage_q;
  assign rd_dir_o   = dir_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign iter_cnt_o = iter_q;

  always_comb begin
    w_din       = '0;
    w_din.valid = rd_en_o;
    w_din.grp   = GRP_MAX_W'(grp_q);
    w_din.stage = ST_MAX_W'(stage_q);
    w_din.dir   = dir_q;
  end

  bp_sched_dly #(
    .LAT (LAT)
  ) u_dly (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (w_abort),
    .en_i      (pe_en_o),
    .din_i     (w_din),
    .tail_o    (w_tail),
    .pending_o (w_pending)
  );

  assign wr_en_o    = w_tail.valid & pe_en_o & ~abort_i;
  assign wr_grp_o   = GA_W'(w_tail.grp);
  assign wr_stage_o = ST_W'(w_tail.stage);
  assign wr_dir_o   = w_tail.dir;

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    iter_d  = iter_q;
    max_d   = max_q;
    grp_d   = grp_q;
    stage_d = stage_q;
    dir_d   = dir_q;
    rdph_d  = rdph_q;
    bub_d   = bub_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          iter_d  = '0;
          grp_d   = '0;
          bub_d   = '0;
          rdph_d  = 1'b1;
          stage_d = ST_LAST;
          dir_d   = DIR_L;
          if (max_iter_i == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RUN;
            busy_d  = 1'b1;
            max_d   = max_iter_i;
          end
        end
      end

      S_RUN: begin
        if (!stall_i) begin
          if (rdph_q) begin
            if (grp_q == GRP_LAST) begin
              grp_d  = '0;
              rdph_d = 1'b0;
              bub_d  = '0;
              // The last stage needs no bubble counting: FLUSH drains it.
              if (w_last_stage) state_d = S_FLUSH;
            end else begin
              grp_d = grp_q + GA_W'(1);
            end
          end else if (bub_q == BUB_LAST) begin
            rdph_d = 1'b1;
            bub_d  = '0;
            if (dir_q == DIR_L) begin
              // Stage 0 is visited by both sweeps: turn around in place.
              if (stage_q == '0) dir_d = DIR_R;
              else               stage_d = stage_q - ST_W'(1);
            end else if (stage_q == ST_LAST) begin
              // Next iteration's L-sweep starts at the same top stage.
              dir_d  = DIR_L;
              iter_d = iter_q + ITER_W'(1);
            end else begin
              stage_d = stage_q + ST_W'(1);
            end
          end else begin
            bub_d = bub_q + BUB_W'(1);
          end
        end
      end

      S_FLUSH: begin
        if (!stall_i && !w_pending) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (w_abort) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      iter_q  <= '0;
      max_q   <= '0;
      grp_q   <= '0;
      stage_q <= '0;
      dir_q   <= DIR_L;
      rdph_q  <= 1'b0;
      bub_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      iter_q  <= iter_d;
      max_q   <= max_d;
      grp_q   <= grp_d;
      stage_q <= stage_d;
      dir_q   <= dir_d;
      rdph_q  <= rdph_d;
      bub_q   <= bub_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bp_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_bp_sched                                                    |
// | Purpose   : Self-checking bench for bp_sched (N_LOG2=3, P_LOG2=1, LAT=3).  |
// |             A per-cycle expectation table is built from the schedule       |
// |             rules in enabled-cycle arithmetic and compared every cycle;    |
// |             literal counts and cycle numbers pin the table.                |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module tb_bp_sched;

  localparam int N_LOG2 = 3;
  localparam int P_LOG2 = 1;
  localparam int LAT    = 3;
  localparam int ITER_W = 6;
  localparam int GA_W   = 1;
  localparam int ST_W   = 2;
  localparam int G      = 1 << (N_LOG2 - 1 - P_LOG2);
  localparam int PER    = G + LAT;
  localparam int SPI    = 2 * N_LOG2;   // stages per iteration
  localparam int MAXC   = 100;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              stall = 1'b0;
  logic [ITER_W-1:0] max_iter = '0;
  logic              busy, done, pe_en, rd_en, rd_dir, wr_en, wr_dir;
  logic [ITER_W-1:0] iter_cnt;
  logic [GA_W-1:0]   rd_grp, wr_grp;
  logic [ST_W-1:0]   rd_stage, wr_stage;

  bp_sched #(
    .N_LOG2 (N_LOG2), .P_LOG2 (P_LOG2), .LAT (LAT), .ITER_W (ITER_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .abort_i    (abort),
    .max_iter_i (max_iter),
    .stall_i    (stall),
    .busy_o     (busy),
    .done_o     (done),
    .iter_cnt_o (iter_cnt),
    .pe_en_o    (pe_en),
    .rd_en_o    (rd_en),
    .rd_grp_o   (rd_grp),
    .rd_stage_o (rd_stage),
    .rd_dir_o   (rd_dir),
    .wr_en_o    (wr_en),
    .wr_grp_o   (wr_grp),
    .wr_stage_o (wr_stage),
    .wr_dir_o   (wr_dir)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit chk_on = 1'b0;

  // Expected outputs per cycle of the current run.
  int e_busy[MAXC], e_done[MAXC], e_pe[MAXC], e_rd[MAXC], e_wr[MAXC], msk[MAXC];
  int e_rg[MAXC], e_rs[MAXC], e_rdir[MAXC], e_it[MAXC];
  int e_wg[MAXC], e_ws[MAXC], e_wdir[MAXC];

  // Observations of the current run.
  int rd_count, wr_count, last_wr, first_wr, first_wr_st, done_cyc, busy_seen;
  int rd_st_log[64];
  int rd_dir_log[64];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},  int'(busy), 0);
    check({tag, "_done"},  int'(done), 0);
    check({tag, "_pe_en"}, int'(pe_en), 0);
    check({tag, "_rd_en"}, int'(rd_en), 0);
    check({tag, "_wr_en"}, int'(wr_en), 0);
    check({tag, "_iter"},  int'(iter_cnt), 0);
  endtask

  // Stage visited at position q (0..SPI-1) within an iteration.
  function automatic int stage_of(input int q);
    return (q < N_LOG2) ? (N_LOG2 - 1 - q) : (q - N_LOG2);
  endfunction

  // Expected schedule: enabled cycle e (1-based, counted after start) is
  // slot (e-1)%PER of global stage (e-1)/PER; slots below G are reads, and
  // each read reappears as a write LAT enabled cycles later.
  task automatic build(input int m, input int slo, input int shi);
    int e, c, total, j, pos, ep;
    for (int i = 0; i < MAXC; i++) begin
      e_busy[i] = 0; e_done[i] = 0; e_pe[i] = 0; e_rd[i] = 0; e_wr[i] = 0;
      e_rg[i] = 0; e_rs[i] = 0; e_rdir[i] = 0; e_it[i] = 0;
      e_wg[i] = 0; e_ws[i] = 0; e_wdir[i] = 0; msk[i] = 1;
    end
    if (m == 0) begin
      e_done[1] = 1;
    end else begin
      total = SPI * PER * m;
      e = 0;
      c = 0;
      while (e < total && c < MAXC - 2) begin
        c++;
        e_busy[c] = 1;
        if (!(c >= slo && c <= shi)) begin
          e++;
          e_pe[c] = 1;
          j   = (e - 1) / PER;
          pos = (e - 1) % PER;
          if (pos < G) begin
            e_rd[c] = 1; e_rg[c] = pos; e_it[c] = j / SPI;
            e_rs[c] = stage_of(j % SPI); e_rdir[c] = ((j % SPI) >= N_LOG2) ? 1 : 0;
          end
          ep = e - LAT;
          if (ep >= 1 && ((ep - 1) % PER) < G) begin
            j = (ep - 1) / PER;
            e_wr[c] = 1; e_wg[c] = (ep - 1) % PER;
            e_ws[c] = stage_of(j % SPI); e_wdir[c] = ((j % SPI) >= N_LOG2) ? 1 : 0;
          end
        end
      end
      e_done[c + 1] = 1;
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      if (cyc >= MAXC) begin
        check("cycle_bound", cyc, MAXC - 1);
      end else if (msk[cyc] != 0) begin
        check("busy",  int'(busy),  e_busy[cyc]);
        check("done",  int'(done),  e_done[cyc]);
        check("pe_en", int'(pe_en), e_pe[cyc]);
        check("rd_en", int'(rd_en), e_rd[cyc]);
        check("wr_en", int'(wr_en), e_wr[cyc]);
        if (e_rd[cyc] != 0 && rd_en) begin
          check("rd_grp",   int'(rd_grp),   e_rg[cyc]);
          check("rd_stage", int'(rd_stage), e_rs[cyc]);
          check("rd_dir",   int'(rd_dir),   e_rdir[cyc]);
          check("iter_cnt", int'(iter_cnt), e_it[cyc]);
        end
        if (e_wr[cyc] != 0 && wr_en) begin
          check("wr_grp",   int'(wr_grp),   e_wg[cyc]);
          check("wr_stage", int'(wr_stage), e_ws[cyc]);
          check("wr_dir",   int'(wr_dir),   e_wdir[cyc]);
        end
      end
      if (rd_en) begin
        if (rd_count < 64) begin
          rd_st_log[rd_count]  = int'(rd_stage);
          rd_dir_log[rd_count] = int'(rd_dir);
        end
        rd_count++;
      end
      if (wr_en) begin
        if (first_wr < 0) begin
          first_wr    = cyc;
          first_wr_st = int'(wr_stage);
        end
        wr_count++;
        last_wr = cyc;
      end
      if (done) done_cyc = cyc;
      if (busy) busy_seen = 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_obs();
    rd_count = 0; wr_count = 0; last_wr = -1; first_wr = -1;
    first_wr_st = -1; done_cyc = -1; busy_seen = 0;
  endtask

  // Called just after a rising edge; that cycle becomes cycle 0 with start.
  task automatic run(input int m, input int slo, input int shi, input int ab,
                     input int ncyc);
    build(m, slo, shi);
    if (ab >= 0) begin
      msk[ab] = 0;
      for (int i = ab + 1; i < MAXC; i++) begin
        e_busy[i] = 0; e_done[i] = 0; e_pe[i] = 0; e_rd[i] = 0; e_wr[i] = 0;
      end
    end
    clear_obs();
    cyc = 0;
    start = 1'b1;
    max_iter = ITER_W'(m);
    chk_on = 1'b1;
    repeat (ncyc) begin
      tick();
      start = 1'b0;
      stall = (cyc >= slo && cyc <= shi);
      abort = (cyc == ab);
    end
    chk_on = 1'b0;
    stall = 1'b0;
    abort = 1'b0;
  endtask

  int exp_st[12] = '{2, 2, 1, 1, 0, 0, 0, 0, 1, 1, 2, 2};

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset_hold");
    rst = 1'b0;
    tick();
    check_idle("reset_release");

    // Basic run, one iteration
    run(1, -1, -1, -1, 34);
    check("basic_reads", rd_count, 12);
    check("basic_writes", wr_count, 12);
    check("basic_first_wr_cyc", first_wr, 4);
    check("basic_first_wr_stage", first_wr_st, 2);
    check("basic_last_wr", last_wr, 30);
    check("basic_done", done_cyc, 31);
    for (int i = 0; i < 12; i++) begin
      check("basic_seq_stage", rd_st_log[i], exp_st[i]);
      check("basic_seq_dir", rd_dir_log[i], (i < 6) ? 0 : 1);
    end

    // Two iterations
    run(2, -1, -1, -1, 64);
    check("iter2_reads", rd_count, 24);
    check("iter2_writes", wr_count, 24);
    check("iter2_last_wr", last_wr, 60);
    check("iter2_done", done_cyc, 61);

    // Stall for cycles 3..6
    run(1, 3, 6, -1, 38);
    check("stall_reads", rd_count, 12);
    check("stall_last_wr", last_wr, 34);
    check("stall_done", done_cyc, 35);

    // Zero iterations
    run(0, -1, -1, -1, 5);
    check("zero_reads", rd_count, 0);
    check("zero_writes", wr_count, 0);
    check("zero_done", done_cyc, 1);
    check("zero_busy", busy_seen, 0);

    // Abort at cycle 8, then restart at cycle 12
    run(1, -1, -1, 8, 12);
    check("abort_no_done", done_cyc, -1);
    check("abort_writes_before", wr_count, 2);
    run(1, -1, -1, -1, 34);
    check("restart_reads", rd_count, 12);
    check("restart_done", done_cyc, 31);

    // Asynchronous reset between edges in cycle 15 of a two-iteration run
    build(2, -1, -1);
    clear_obs();
    cyc = 0;
    start = 1'b1;
    max_iter = ITER_W'(2);
    chk_on = 1'b1;
    repeat (15) begin
      tick();
      start = 1'b0;
    end
    #2;
    chk_on = 1'b0;
    check("pre_rst_busy", int'(busy), 1);
    check("pre_rst_wr_en", int'(wr_en), 1);
    rst = 1'b1;
    #1;
    check_idle("async_rst");
    start = 1'b1;
    max_iter = ITER_W'(1);
    @(posedge clk);
    #1;
    check_idle("rst_start_ignored");
    rst = 1'b0;
    start = 1'b0;
    tick();
    check_idle("post_rst");
    run(1, -1, -1, -1, 34);
    check("post_rst_reads", rd_count, 12);
    check("post_rst_done", done_cyc, 31);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
